// File: rtl/ham_15_11_encoder.sv
// ham_15_11_encoder: Hamming(15,11) encoder feeding a 2-entry output FIFO with a delivered-word counter.
// Define HAM_ERR_INJECT_EN to add inj_pos, which flips one stored codeword bit for fault injection.
module ham_15_11_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] d,
    input  logic        d_valid,
    output logic        d_ready,
`ifdef HAM_ERR_INJECT_EN
    input  logic [3:0]  inj_pos,
`endif
    output logic [14:0] c,
    output logic        c_valid,
    input  logic        c_ready,
    output logic [15:0] wcount
);
    logic [14:0] mem [0:1];
    logic        wr, rd;
    logic [1:0]  cnt;
    logic [14:0] cw, flip;
    logic        push, pop;
    always_comb begin
        cw = {d[10:4],
              ^{d[4], d[5], d[6], d[7], d[8], d[9], d[10]},
              d[3:1],
              ^{d[1], d[2], d[3], d[7], d[8], d[9], d[10]},
              d[0],
              ^{d[0], d[2], d[3], d[5], d[6], d[9], d[10]},
              ^{d[0], d[1], d[3], d[4], d[6], d[8], d[10]}};
`ifdef HAM_ERR_INJECT_EN
        flip = (inj_pos == 4'd0) ? 15'd0 : 15'd1 << (inj_pos - 4'd1);
`else
        flip = 15'd0;
`endif
    end
    // reset gates d_ready so nothing is offered while the FIFO is held clear
    assign d_ready = ~reset & (cnt != 2'd2);
    assign c_valid = cnt != 2'd0;
    assign c       = mem[rd];
    assign push    = d_valid & d_ready;
    assign pop     = c_valid & c_ready;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem[0] <= 15'd0;
            mem[1] <= 15'd0;
            wr     <= 1'b0;
            rd     <= 1'b0;
            cnt    <= 2'd0;
            wcount <= 16'd0;
        end else begin
            if (push) begin
                mem[wr] <= cw ^ flip;
                wr      <= ~wr;
            end
            if (pop) begin
                rd     <= ~rd;
                wcount <= wcount + 16'd1;
            end
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_ham_15_11_encoder.sv
// tb_ham_15_11_encoder: randomized self-checking bench against a position-based Hamming reference and a queue FIFO model.
module tb_ham_15_11_encoder;
    logic        clk = 0;
    logic        reset = 1;
    logic [10:0] d = '0;
    logic        d_valid = 0;
    logic        d_ready;
    logic [3:0]  inj_pos = '0;
    logic [14:0] c;
    logic        c_valid;
    logic        c_ready = 0;
    logic [15:0] wcount;
    int          pass_n = 0, total_n = 0;
    logic [14:0] q[$];
    logic [15:0] wc_m = '0;

    ham_15_11_encoder dut (
        .clk(clk), .reset(reset), .d(d), .d_valid(d_valid), .d_ready(d_ready),
`ifdef HAM_ERR_INJECT_EN
        .inj_pos(inj_pos),
`endif
        .c(c), .c_valid(c_valid), .c_ready(c_ready), .wcount(wcount)
    );

    always #5 clk = ~clk;

    // data fills non-power-of-two positions in order; parity p covers every position sharing bit p
    function automatic logic [14:0] ref_enc(input logic [10:0] x);
        logic [14:0] w;
        int k;
        w = '0;
        k = 0;
        for (int p = 1; p <= 15; p++)
            if ((p & (p - 1)) != 0) begin
                w[p-1] = x[k];
                k++;
            end
        for (int p = 1; p <= 8; p = p * 2)
            for (int j = 1; j <= 15; j++)
                if ((j & p) != 0 && j != p) w[p-1] = w[p-1] ^ w[j-1];
        return w;
    endfunction

    function automatic logic [10:0] ref_dec(input logic [14:0] w);
        logic [10:0] x;
        int syn, k;
        syn = 0;
        k = 0;
        for (int j = 1; j <= 15; j++) if (w[j-1]) syn = syn ^ j;
        if (syn != 0) w[syn-1] = ~w[syn-1];
        for (int p = 1; p <= 15; p++)
            if ((p & (p - 1)) != 0) begin
                x[k] = w[p-1];
                k++;
            end
        return x;
    endfunction

    function automatic logic [14:0] inj_mask(input logic [3:0] pos);
        logic [14:0] m;
        m = '0;
        if (pos != 0) m[pos-1] = 1'b1;
        return m;
    endfunction

    // drive one cycle from a negedge, update the model at the posedge, return at the next negedge
    task automatic tick(input logic dv, input logic [10:0] dd, input logic cr);
        logic push, pop;
        d_valid = dv;
        d = dd;
        c_ready = cr;
        push = dv && q.size() < 2;
        pop = cr && q.size() > 0;
        @(posedge clk);
        if (pop) begin
            void'(q.pop_front());
            wc_m = wc_m + 16'd1;
        end
        if (push) q.push_back(ref_enc(dd) ^ inj_mask(inj_pos));
        @(negedge clk);
    endtask

    task automatic do_reset();
        d_valid = 0;
        c_ready = 0;
        reset = 1;
        q.delete();
        wc_m = '0;
        @(negedge clk);
        reset = 0;
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total_n++; if (d_ready !== 1'b0) $display("FAIL reset_d_ready got %b want 0", d_ready); else pass_n++;
        total_n++; if (c_valid !== 1'b0) $display("FAIL reset_c_valid got %b want 0", c_valid); else pass_n++;
        total_n++; if (wcount !== 16'h0000) $display("FAIL reset_wcount got %h want 0000", wcount); else pass_n++;
        total_n++; if (c !== 15'h0000) $display("FAIL reset_c got %h want 0000", c); else pass_n++;
        reset = 0;
        #1;
        total_n++; if (d_ready !== 1'b1) $display("FAIL release_d_ready got %b want 1", d_ready); else pass_n++;
    endtask

    task automatic test_single();
        tick(1, 11'h001, 1);
        total_n++; if (c_valid !== 1'b1) $display("FAIL single_c_valid got %b want 1", c_valid); else pass_n++;
        total_n++; if (c !== 15'h0007) $display("FAIL single_c got %h want 0007", c); else pass_n++;
        tick(0, 11'h000, 1);
        total_n++; if (c_valid !== 1'b0) $display("FAIL single_c_valid_drop got %b want 0", c_valid); else pass_n++;
        total_n++; if (wcount !== 16'd1) $display("FAIL single_wcount got %h want 0001", wcount); else pass_n++;
    endtask

    task automatic test_back_to_back();
        logic [10:0] din [3];
        logic [14:0] cexp [3];
        din = '{11'h7FF, 11'h400, 11'h000};
        cexp = '{15'h7FFF, 15'h408B, 15'h0000};
        for (int i = 0; i < 3; i++) begin
            tick(1, din[i], 1);
            total_n++; if (c_valid !== 1'b1) $display("FAIL b2b_valid[%0d] got %b want 1", i, c_valid); else pass_n++;
            total_n++; if (c !== cexp[i]) $display("FAIL b2b_c[%0d] got %h want %h", i, c, cexp[i]); else pass_n++;
        end
        tick(0, 11'h000, 1);
        total_n++; if (c_valid !== 1'b0) $display("FAIL b2b_drain got %b want 0", c_valid); else pass_n++;
        total_n++; if (wcount !== wc_m) $display("FAIL b2b_wcount got %h want %h", wcount, wc_m); else pass_n++;
    endtask

    task automatic test_backpressure();
        logic [10:0] w0, w1, w2;
        w0 = 11'($urandom);
        w1 = 11'($urandom);
        w2 = 11'($urandom);
        tick(1, w0, 0);
        tick(1, w1, 0);
        total_n++; if (d_ready !== 1'b0) $display("FAIL bp_full_ready got %b want 0", d_ready); else pass_n++;
        tick(1, w2, 0);
        total_n++; if (d_ready !== 1'b0) $display("FAIL bp_held_ready got %b want 0", d_ready); else pass_n++;
        total_n++; if (c !== ref_enc(w0)) $display("FAIL bp_held_c got %h want %h", c, ref_enc(w0)); else pass_n++;
        tick(0, 11'h000, 1);
        total_n++; if (d_ready !== 1'b1) $display("FAIL bp_ready_return got %b want 1", d_ready); else pass_n++;
        total_n++; if (c !== ref_enc(w1)) $display("FAIL bp_second_c got %h want %h", c, ref_enc(w1)); else pass_n++;
        tick(0, 11'h000, 1);
        total_n++; if (c_valid !== 1'b0) $display("FAIL bp_third_dropped got %b want 0", c_valid); else pass_n++;
        total_n++; if (wcount !== wc_m) $display("FAIL bp_wcount got %h want %h", wcount, wc_m); else pass_n++;
    endtask

    task automatic test_reset_mid();
        tick(1, 11'($urandom), 0);
        tick(1, 11'($urandom), 0);
        d_valid = 0;
        reset = 1;
        q.delete();
        wc_m = '0;
        #1;
        total_n++; if (c_valid !== 1'b0) $display("FAIL mid_c_valid got %b want 0", c_valid); else pass_n++;
        total_n++; if (wcount !== 16'h0000) $display("FAIL mid_wcount got %h want 0000", wcount); else pass_n++;
        total_n++; if (c !== 15'h0000) $display("FAIL mid_c got %h want 0000", c); else pass_n++;
        total_n++; if (d_ready !== 1'b0) $display("FAIL mid_d_ready got %b want 0", d_ready); else pass_n++;
        @(negedge clk);
        reset = 0;
        #1;
        total_n++; if (d_ready !== 1'b1) $display("FAIL mid_release_ready got %b want 1", d_ready); else pass_n++;
        tick(0, 11'h000, 1);
        total_n++; if (c_valid !== 1'b0) $display("FAIL mid_stale_valid got %b want 0", c_valid); else pass_n++;
        total_n++; if (wcount !== 16'h0000) $display("FAIL mid_stale_wcount got %h want 0000", wcount); else pass_n++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            total_n++; if (d_ready !== (q.size() < 2)) $display("FAIL rnd_d_ready[%0d] got %b want %b", i, d_ready, q.size() < 2); else pass_n++;
            total_n++; if (c_valid !== (q.size() > 0)) $display("FAIL rnd_c_valid[%0d] got %b want %b", i, c_valid, q.size() > 0); else pass_n++;
            if (q.size() > 0) begin
                total_n++; if (c !== q[0]) $display("FAIL rnd_c[%0d] got %h want %h", i, c, q[0]); else pass_n++;
            end
            total_n++; if (wcount !== wc_m) $display("FAIL rnd_wcount[%0d] got %h want %h", i, wcount, wc_m); else pass_n++;
            tick(1'($urandom), 11'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_wrap();
        int guard;
        do_reset();
        guard = 0;
        while (wc_m != 16'hFFFF && guard < 70000) begin
            tick(1, 11'($urandom), 1);
            guard++;
        end
        total_n++; if (wcount !== 16'hFFFF) $display("FAIL wrap_preload got %h want ffff", wcount); else pass_n++;
        tick(0, 11'h000, 1);
        total_n++; if (wcount !== 16'h0000) $display("FAIL wrap_rollover got %h want 0000", wcount); else pass_n++;
    endtask

`ifdef HAM_ERR_INJECT_EN
    task automatic test_inject();
        logic [14:0] got;
        inj_pos = 4'd5;
        tick(1, 11'h000, 0);
        inj_pos = 4'd0;
        got = c;
        total_n++; if (c !== 15'h0010) $display("FAIL inj_c got %h want 0010", c); else pass_n++;
        total_n++; if (ref_dec(got) !== 11'h000) $display("FAIL inj_decode got %h want 000", ref_dec(got)); else pass_n++;
        tick(0, 11'h000, 1);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef HAM_ERR_INJECT_EN
        test_inject();
`endif
        test_wrap();
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule

// File: doc/ham_15_11_encoder.md
HAM_15_11_ENCODER -- requirements
Module: ham_15_11_encoder

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have the port d, input, 11 bits: data word to encode.
REQ-004 The block SHALL have the port d_valid, input, 1 bit: d is valid this cycle.
REQ-005 The block SHALL have the port d_ready, output, 1 bit: the block accepts d this cycle.
REQ-006 The block SHALL have the port c, output, 15 bits: codeword at the head of the buffer.
REQ-007 The block SHALL have the port c_valid, output, 1 bit: c is valid.
REQ-008 The block SHALL have the port c_ready, input, 1 bit: the consumer accepts c this cycle.
REQ-009 The block SHALL have the port wcount, output, 16 bits: count of codewords delivered.

Function
REQ-010 The block SHALL treat an input handshake as d_valid & d_ready at a rising clk edge, and an output handshake as c_valid & c_ready at a rising clk edge.
REQ-011 The block SHALL place data bits as c2=d0, c4=d1, c5=d2, c6=d3, c8=d4, c9=d5, c10=d6, c11=d7, c12=d8, c13=d9, c14=d10.
REQ-012 The block SHALL compute parity as c0=d0^d1^d3^d4^d6^d8^d10, c1=d0^d2^d3^d5^d6^d9^d10, c3=d1^d2^d3^d7^d8^d9^d10, c7=d4^d5^d6^d7^d8^d9^d10 (even parity; syndrome of a clean word = 0).
REQ-013 The block SHALL encode in the accept cycle and write the codeword into a 2-entry FIFO; c_valid SHALL rise one cycle after the first handshake into an empty FIFO (latency 1, no combinational d-to-c path).
REQ-014 The block SHALL drive d_ready = FIFO not full, combinationally from registered occupancy only (never from c_ready).
REQ-015 The block SHALL drive c_valid = FIFO not empty, with c = oldest entry, held stable while c_valid & !c_ready.
REQ-016 On a simultaneous push and pop with occupancy 1, occupancy SHALL remain 1 and order SHALL be preserved.
REQ-017 With occupancy 2, d_ready SHALL be 0 and d_valid SHALL be ignored; a pop in that cycle SHALL set d_ready=1 on the next cycle.
REQ-018 With occupancy 0, c_ready SHALL have no effect.
REQ-019 FIFO read/write pointers SHALL be 1 bit each and wrap 1->0.
REQ-020 wcount SHALL increment by 1 on each output handshake, wrapping 16'hFFFF->16'h0000.

Reset
REQ-021 Asserting reset SHALL immediately clear FIFO occupancy and pointers and set wcount=0, c_valid=0, d_ready=0, and c=15'h0000.
REQ-022 While reset is high, d_ready SHALL be 0; in the first clk cycle after reset deasserts, d_ready SHALL be 1.
REQ-023 A reset mid-transfer SHALL discard buffered words with no output handshake completing.

Configuration
REQ-024 When macro HAM_ERR_INJECT_EN is defined, the block SHALL add inputs inj_pos[3:0] (qualified by the input handshake) and SHALL store the codeword with bit (inj_pos-1) inverted for inj_pos 1..15, and unmodified for inj_pos=0.
REQ-025 When HAM_ERR_INJECT_EN is undefined, inj_pos SHALL be absent and codewords SHALL be stored unmodified.

Verification
REQ-026 The bench SHALL cover: reset, then d=11'h001 with d_valid=1 and c_ready=1 -> c=15'h0007, c_valid for 1 cycle, wcount=1.
REQ-027 The bench SHALL cover: d=11'h7FF, then 11'h400, then 11'h000 back-to-back with c_ready=1 -> c=15'h7FFF, 15'h408B, 15'h0000 on consecutive cycles.
REQ-028 The bench SHALL cover: c_ready=0 with 3 words offered -> 2 accepted; d_ready=0 with c held at the first word; raising c_ready drains the words in order and d_ready returns 1 the cycle after the first pop.
REQ-029 The bench SHALL cover: asserting reset with 2 words buffered -> c_valid=0 and wcount=0 immediately; no stale word after release.
REQ-030 The bench SHALL cover: wcount preloaded via 65535 handshakes, then one more handshake -> wcount=16'h0000.
REQ-031 With HAM_ERR_INJECT_EN defined, the bench SHALL cover: d=11'h000 with inj_pos=5 -> c=15'h0010; feeding c to the existing decoder -> q=11'h000.
